read_loader: RTL and testbench
==============================

READ_LOADER -- requirements
Module: read_loader

Interface
REQ-001 SHALL have parameter READ_LEN, default 76: symbols per read, fixed for all reads.
REQ-002 SHALL have parameter SYMS_PER_BEAT, default 16: 4-bit symbol nibbles per 64-bit beat; derived NBEATS = ceil(READ_LEN/SYMS_PER_BEAT), 5 at defaults.
REQ-003 SHALL have port clk, input, 1: the single clock. One clock only; reset is asynchronous and active-low.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port s_axis_read, Axi4StreamIf.slave, DW_BYTES=8: packed read stream.
REQ-006 SHALL have port read, output, Symbol[0:READ_LEN-1]: read presented to the seeder.
REQ-007 SHALL have port read_id, output, RID_W: id of the presented read.
REQ-008 SHALL have port start, output, 1: one-cycle seeder start pulse.
REQ-009 SHALL have port seed_finish, input, 1: seeder finish pulse.
REQ-010 SHALL have port seed_busy, input, 1: seeder busy level.
REQ-011 SHALL have port fmt_err, output, 1: one-cycle pulse per dropped malformed read.
REQ-012 SHALL have port read_cnt, output, 32: reads issued, wrapping.
REQ-013 SHALL have port drop_cnt, output, 16: reads dropped, saturating at 16'hFFFF.

Function
REQ-014 SHALL accept packets of one header beat (read id in tdata[RID_W-1:0]) followed by NBEATS data beats; symbol k sits in beat k/SYMS_PER_BEAT, bits [4*(k%SYMS_PER_BEAT)+:4].
REQ-015 SHALL map nibble 0..3 to A,C,G,T and any other value to sym_N; padding nibbles past READ_LEN SHALL be ignored.
REQ-016 SHALL hold two read slots (double buffer): a fill slot written from the stream and a present slot driving read/read_id.
REQ-017 SHALL run a receive FSM with states R_Header, R_Data, R_Drain; beat counter 0..NBEATS-1.
REQ-018 SHALL assert tready in R_Header/R_Data only while the fill slot is empty; always in R_Drain.
REQ-019 SHALL go R_Header->R_Data on a header beat without tlast; R_Data->R_Header on beat NBEATS-1 with tlast, marking the fill slot full.
REQ-020 SHALL treat as malformed: tlast on the header, tlast before beat NBEATS-1, or no tlast on beat NBEATS-1; the read SHALL be dropped, fmt_err pulsed, drop_cnt incremented.
REQ-021 SHALL go to R_Drain after a missing tlast and consume beats until tlast, then return to R_Header; other malformed cases SHALL return directly to R_Header.
REQ-022 SHALL run an issue FSM with states I_Empty, I_Ready, I_Running.
REQ-023 SHALL, when the present slot is empty and the fill slot is full, swap slots in one cycle and enter I_Ready.
REQ-024 SHALL, in I_Ready with seed_busy low, pulse start for exactly one cycle, increment read_cnt and enter I_Running.
REQ-025 SHALL hold read and read_id stable from the swap through the seed_finish cycle inclusive.
REQ-026 SHALL, in I_Running on seed_finish, empty the present slot; if the fill slot is full in that cycle, swap and return to I_Ready, else go to I_Empty.
REQ-027 SHALL give start latency of 2 cycles after the accepted last data beat when the seeder is idle and the present slot is empty.
REQ-028 SHALL let a fill-complete and a seed_finish in the same cycle swap on the next cycle without loss; the fill slot SHALL not accept beats until freed.
REQ-029 SHALL ignore seed_finish outside I_Running.

Reset
REQ-030 SHALL, on reset_n low, asynchronously clear: both slots to empty, read to all sym_N, read_id 0, start 0, fmt_err 0, tready 0, read_cnt 0, drop_cnt 0; FSMs to R_Header and I_Empty.
REQ-031 SHALL, on reset mid-packet, discard the partial read; the first beat after reset SHALL be treated as a header.

Structure
REQ-032 SHALL take Symbol, sym_N, RID_W from package BwaMemDefines; the nibble-to-Symbol mapping function SHALL be added to that package.
REQ-033 SHALL be a single module without sub-modules; the two slots are a register array indexed by a 1-bit present pointer.

Verification
REQ-034 SHALL be covered: one well-formed read id=7, all nibbles 2 -> start 2 cycles after last beat, read all G, read_id 7, read_cnt 1.
REQ-035 SHALL be covered: nibble 4'hF at symbol 0 -> read[0]=sym_N.
REQ-036 SHALL be covered: tlast on data beat 2 -> fmt_err pulse, drop_cnt 1, no start; the next good read is issued normally.
REQ-037 SHALL be covered: no tlast on beat 4, tlast 3 beats later -> drain, fmt_err once, next packet accepted.
REQ-038 SHALL be covered: three back-to-back reads, seeder busy 100 cycles each -> tready low while both slots are full, three starts in order, read/read_id stable during each run.
REQ-039 SHALL be covered: reset_n pulse mid-header or mid-data -> all outputs at reset values immediately; a fresh packet afterwards is issued correctly.

Source files
------------

// File: rtl/BwaMemDefines.sv
// BwaMemDefines -- shared types for the BWA-MEM read front end.
//   Symbol          : 3-bit base code (A, C, G, T, N).
//   RID_W           : width of a read id.
//   R_* / I_*       : state codes of the read loader's receive and issue FSMs.
//   fsm_dbg_t       : both FSM states, exported for observation.
//   nibble_to_sym() : converts a packed 4-bit nibble to a Symbol.
package BwaMemDefines;

    typedef enum logic [2:0] {
        sym_A = 3'd0,
        sym_C = 3'd1,
        sym_G = 3'd2,
        sym_T = 3'd3,
        sym_N = 3'd4
    } Symbol;

    localparam int RID_W = 16;

    // Receive FSM.
    localparam logic [1:0] R_Header = 2'd0;
    localparam logic [1:0] R_Data   = 2'd1;
    localparam logic [1:0] R_Drain  = 2'd2;

    // Issue FSM.
    localparam logic [1:0] I_Empty   = 2'd0;
    localparam logic [1:0] I_Ready   = 2'd1;
    localparam logic [1:0] I_Running = 2'd2;

    typedef struct packed {
        logic [1:0] rx_state;
        logic [1:0] issue_state;
    } fsm_dbg_t;

    // Nibbles 0..3 are real bases; every other code is an ambiguous base.
    function automatic Symbol nibble_to_sym(input logic [3:0] nib);
        Symbol s;
        case (nib)
            4'd0:    s = sym_A;
            4'd1:    s = sym_C;
            4'd2:    s = sym_G;
            4'd3:    s = sym_T;
            default: s = sym_N;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/Axi4StreamIf.sv
// Axi4StreamIf -- minimal AXI4-Stream bundle.
//   tdata  : 8*DW_BYTES-bit payload
//   tvalid : source has a beat
//   tready : sink can take a beat
//   tlast  : final beat of a packet
// A beat transfers on a rising clock edge where tvalid and tready are both
// high; the source holds tdata/tlast stable while tvalid is high and tready
// is low, and tready may depend on sink state but never on tvalid.
interface Axi4StreamIf #(
    parameter int DW_BYTES = 8
);
    logic [8*DW_BYTES-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/read_loader.sv
// read_loader -- unpacks fixed-length reads from a 64-bit AXI4-Stream and
// hands them one at a time to the seeder through a double buffer.
//   clk, reset_n  : single clock, asynchronous active-low reset
//   s_axis_read   : packets = 1 header beat (id in tdata[RID_W-1:0]) + NBEATS data beats
//   read, read_id : read currently presented to the seeder
//   start         : one-cycle pulse launching the seeder on the presented read
//   seed_finish   : seeder done pulse; seed_busy : seeder busy level
//   fmt_err       : one-cycle pulse per dropped malformed packet
//   read_cnt      : reads issued (wraps); drop_cnt : reads dropped (saturates)
//   fsm_state     : receive and issue FSM states for observation
module read_loader
    import BwaMemDefines::*;
#(
    parameter int READ_LEN      = 76,
    parameter int SYMS_PER_BEAT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    Axi4StreamIf.slave       s_axis_read,
    output Symbol            read [0:READ_LEN-1],
    output logic [RID_W-1:0] read_id,
    output logic             start,
    input  logic             seed_finish,
    input  logic             seed_busy,
    output logic             fmt_err,
    output logic [31:0]      read_cnt,
    output logic [15:0]      drop_cnt,
    output fsm_dbg_t         fsm_state
);

    localparam int NBEATS = (READ_LEN + SYMS_PER_BEAT - 1) / SYMS_PER_BEAT;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

    // Two read slots; pres_ptr selects the one driving the seeder, the
    // other is the fill slot written from the stream.
    Symbol            slot_sym [0:1][0:READ_LEN-1];
    logic [RID_W-1:0] slot_id  [0:1];
    logic [1:0]       slot_full;
    logic             pres_ptr;
    logic             fill_ptr;

    logic [1:0]       rx_state;
    logic [1:0]       issue_state;
    logic [BCW-1:0]   beat_cnt;
    logic             rx_en;

    logic             tready_int;
    logic             hs;
    logic             is_last;
    logic             drop;
    logic             fill_done;

    assign fill_ptr = ~pres_ptr;

    // rx_en keeps tready low through reset and the first cycle after it.
    always_comb begin
        tready_int = rx_en && ((rx_state == R_Drain) || !slot_full[fill_ptr]);
        hs         = s_axis_read.tvalid && tready_int;
        is_last    = (beat_cnt == LAST_BEAT);
        // A data beat is malformed exactly when tlast disagrees with being
        // the last beat; a header is malformed when it carries tlast.
        drop       = hs && (((rx_state == R_Header) && s_axis_read.tlast) ||
                            ((rx_state == R_Data) && (is_last != s_axis_read.tlast)));
        fill_done  = hs && (rx_state == R_Data) && is_last && s_axis_read.tlast;
    end

    assign s_axis_read.tready = tready_int;

    // Receive FSM, header capture, error reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= R_Header;
            beat_cnt   <= '0;
            rx_en      <= 1'b0;
            fmt_err    <= 1'b0;
            drop_cnt   <= '0;
            slot_id[0] <= '0;
            slot_id[1] <= '0;
        end else begin
            rx_en   <= 1'b1;
            fmt_err <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            case (rx_state)
                R_Header: begin
                    if (hs) begin
                        slot_id[fill_ptr] <= s_axis_read.tdata[RID_W-1:0];
                        beat_cnt          <= '0;
                        if (!s_axis_read.tlast) begin
                            rx_state <= R_Data;
                        end
                    end
                end
                R_Data: begin
                    if (hs) begin
                        if (is_last) begin
                            // Missing tlast: swallow the rest of the packet.
                            rx_state <= s_axis_read.tlast ? R_Header : R_Drain;
                        end else if (s_axis_read.tlast) begin
                            rx_state <= R_Header;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                R_Drain: begin
                    if (hs && s_axis_read.tlast) begin
                        rx_state <= R_Header;
                    end
                end
                default: rx_state <= R_Header;
            endcase
        end
    end

    // Symbol unpacking into the fill slot. A dropped read leaves partial
    // data behind, which the next packet overwrites before it is marked full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < READ_LEN; k++) begin
                    slot_sym[s][k] <= sym_N;
                end
            end
        end else if (hs && (rx_state == R_Data)) begin
            for (int k = 0; k < READ_LEN; k++) begin
                if (beat_cnt == BCW'(k / SYMS_PER_BEAT)) begin
                    slot_sym[fill_ptr][k] <=
                        nibble_to_sym(s_axis_read.tdata[4*(k % SYMS_PER_BEAT) +: 4]);
                end
            end
        end
    end

    // Issue FSM. The present slot is full exactly while in I_Ready or
    // I_Running. A fill that completes in the seed_finish cycle is not yet
    // visible here, so the swap happens one cycle later from I_Empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full   <= 2'b00;
            pres_ptr    <= 1'b0;
            issue_state <= I_Empty;
            start       <= 1'b0;
            read_cnt    <= '0;
        end else begin
            start <= 1'b0;
            if (fill_done) begin
                slot_full[fill_ptr] <= 1'b1;
            end
            case (issue_state)
                I_Empty: begin
                    if (slot_full[fill_ptr]) begin
                        pres_ptr    <= ~pres_ptr;
                        issue_state <= I_Ready;
                    end
                end
                I_Ready: begin
                    if (!seed_busy) begin
                        start       <= 1'b1;
                        read_cnt    <= read_cnt + 32'd1;
                        issue_state <= I_Running;
                    end
                end
                I_Running: begin
                    if (seed_finish) begin
                        slot_full[pres_ptr] <= 1'b0;
                        if (slot_full[fill_ptr]) begin
                            pres_ptr    <= ~pres_ptr;
                            issue_state <= I_Ready;
                        end else begin
                            issue_state <= I_Empty;
                        end
                    end
                end
                default: issue_state <= I_Empty;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < READ_LEN; k++) begin
            read[k] = slot_sym[pres_ptr][k];
        end
        read_id = slot_id[pres_ptr];
    end

    assign fsm_state.rx_state    = rx_state;
    assign fsm_state.issue_state = issue_state;

endmodule

// File: tb/tb_read_loader.sv
module tb_read_loader;
    import BwaMemDefines::*;

    localparam int READ_LEN = 76;
    localparam int SPB      = 16;
    localparam int NBEATS   = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    Axi4StreamIf #(.DW_BYTES(8)) axis ();
    Symbol            rd [0:READ_LEN-1];
    logic [RID_W-1:0] rid;
    logic             start;
    logic             seed_finish;
    logic             seed_busy;
    logic             fmt_err;
    logic [31:0]      read_cnt;
    logic [15:0]      drop_cnt;
    fsm_dbg_t         fsm_state;

    read_loader #(.READ_LEN(READ_LEN), .SYMS_PER_BEAT(SPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_axis_read (axis),
        .read        (rd),
        .read_id     (rid),
        .start       (start),
        .seed_finish (seed_finish),
        .seed_busy   (seed_busy),
        .fmt_err     (fmt_err),
        .read_cnt    (read_cnt),
        .drop_cnt    (drop_cnt),
        .fsm_state   (fsm_state)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [RID_W-1:0] exp_q[$];
    Symbol            exp_first_q[$];
    Symbol            exp_fill_q[$];

    int               start_count = 0;
    int               start_cyc   = 0;
    int               err_seen    = 0;
    int               last_acc_cyc = 0;
    logic [RID_W-1:0] run_exp_id;
    Symbol            run_exp_fill;
    int               nbad;

    task automatic push_exp(input logic [RID_W-1:0] id, input Symbol first, input Symbol fill);
        exp_q.push_back(id);
        exp_first_q.push_back(first);
        exp_fill_q.push_back(fill);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (fmt_err) err_seen++;
            if (start) begin
                start_count++;
                start_cyc = cyc;
                check_val("start_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    run_exp_id   = exp_q.pop_front();
                    run_exp_fill = exp_fill_q.pop_front();
                    check_val("read_id", 64'(rid), 64'(run_exp_id));
                    check_val("read_sym0", 64'(rd[0]), 64'(exp_first_q.pop_front()));
                    nbad = 0;
                    for (int k = 1; k < READ_LEN; k++) begin
                        if (rd[k] !== run_exp_fill) nbad++;
                    end
                    check_val("read_body", 64'(nbad), 64'd0);
                end
            end
        end
    end

    // ---------------- seeder model ----------------
    int busy_cycles = 5;
    initial begin
        seed_busy   = 1'b0;
        seed_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && start) begin
                seed_busy = 1'b1;
                repeat (busy_cycles) @(negedge clk);
                // Presented read must still be the issued one in the finish cycle.
                check_val("hold_id", 64'(rid), 64'(run_exp_id));
                check_val("hold_sym", 64'(rd[READ_LEN-1]), 64'(run_exp_fill));
                seed_finish = 1'b1;
                @(negedge clk);
                seed_finish = 1'b0;
                seed_busy   = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [63:0] d, input logic l);
        int w;
        w = 0;
        axis.tdata  = d;
        axis.tlast  = l;
        axis.tvalid = 1'b1;
        while (!axis.tready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!axis.tready) check_val("beat_accept", 64'(axis.tready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        axis.tvalid  = 1'b0;
        axis.tlast   = 1'b0;
        last_acc_cyc = cyc;
    endtask

    // mode 0: good; 1: tlast on data beat 2; 2: no tlast on last beat, then
    // 3 extra beats ending in tlast; 3: header + 2 data beats, then stop.
    task automatic send_read(input logic [15:0] id, input logic [3:0] first_nib,
                             input logic [3:0] fill_nib, input int mode);
        logic [63:0] d;
        logic [3:0]  nib;
        logic        l;
        send_beat({48'hA5A5_0F0F_C3C3, id}, 1'b0);
        for (int b = 0; b < NBEATS; b++) begin
            if (mode == 3 && b == 2) return;
            for (int j = 0; j < SPB; j++) begin
                int k;
                k = b * SPB + j;
                if (k == 0)             nib = first_nib;
                else if (k < READ_LEN)  nib = fill_nib;
                else                    nib = 4'hE;
                d[4*j +: 4] = nib;
            end
            l = (b == NBEATS - 1) && (mode != 2);
            if (mode == 1 && b == 2) l = 1'b1;
            send_beat(d, l);
            if (mode == 1 && b == 2) return;
        end
        if (mode == 2) begin
            for (int i = 0; i < 3; i++) send_beat(64'h0123_4567_89AB_CDEF, i == 2);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int w;
        w = 0;
        while (start_count < target && w < budget) begin
            @(negedge clk);
            w++;
        end
        check_val("start_count", 64'(start_count), 64'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tready"}, 64'(axis.tready), 64'd0);
        check_val({tag, "_start"}, 64'(start), 64'd0);
        check_val({tag, "_fmt_err"}, 64'(fmt_err), 64'd0);
        check_val({tag, "_read_cnt"}, 64'(read_cnt), 64'd0);
        check_val({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        check_val({tag, "_read_id"}, 64'(rid), 64'd0);
        check_val({tag, "_sym0"}, 64'(rd[0]), 64'(sym_N));
        check_val({tag, "_symlast"}, 64'(rd[READ_LEN-1]), 64'(sym_N));
        check_val({tag, "_rx_state"}, 64'(fsm_state.rx_state), 64'(R_Header));
        check_val({tag, "_issue_state"}, 64'(fsm_state.issue_state), 64'(I_Empty));
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #300000;
        $display("FAIL global_timeout: got=%0d starts exp=finish", start_count);
        $fatal(1, "time limit");
    end

    // ---------------- directed tests ----------------
    int prev;
    initial begin
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        reset_n     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Well-formed read id 7, all G; start two cycles after the last beat.
        push_exp(16'd7, sym_G, sym_G);
        send_read(16'd7, 4'h2, 4'h2, 0);
        wait_starts(1, 50);
        check_val("latency_1", 64'(start_cyc - last_acc_cyc), 64'd2);
        check_val("read_cnt_1", 64'(read_cnt), 64'd1);
        repeat (busy_cycles + 8) @(negedge clk);

        // Nibble F at symbol 0 becomes sym_N; rest C.
        push_exp(16'd9, sym_N, sym_C);
        send_read(16'd9, 4'hF, 4'h1, 0);
        wait_starts(2, 50);
        check_val("latency_2", 64'(start_cyc - last_acc_cyc), 64'd2);
        repeat (busy_cycles + 8) @(negedge clk);

        // Early tlast on data beat 2: dropped, then a good read.
        prev = start_count;
        send_read(16'd3, 4'h0, 4'h0, 1);
        repeat (20) @(negedge clk);
        check_val("early_fmt_err", 64'(err_seen), 64'd1);
        check_val("early_drop_cnt", 64'(drop_cnt), 64'd1);
        check_val("early_no_start", 64'(start_count), 64'(prev));
        push_exp(16'd4, sym_T, sym_T);
        send_read(16'd4, 4'h3, 4'h3, 0);
        wait_starts(3, 50);
        check_val("read_cnt_3", 64'(read_cnt), 64'd3);
        repeat (busy_cycles + 8) @(negedge clk);

        // Missing tlast: drained, single fmt_err, next packet accepted.
        prev = start_count;
        send_read(16'd5, 4'h1, 4'h1, 2);
        repeat (20) @(negedge clk);
        check_val("drain_fmt_err", 64'(err_seen), 64'd2);
        check_val("drain_drop_cnt", 64'(drop_cnt), 64'd2);
        check_val("drain_no_start", 64'(start_count), 64'(prev));
        check_val("drain_rx_state", 64'(fsm_state.rx_state), 64'(R_Header));
        push_exp(16'd6, sym_A, sym_G);
        send_read(16'd6, 4'h0, 4'h2, 0);
        wait_starts(4, 50);
        check_val("read_cnt_4", 64'(read_cnt), 64'd4);
        repeat (busy_cycles + 8) @(negedge clk);

        // Three back-to-back reads against a slow seeder.
        busy_cycles = 100;
        push_exp(16'd10, sym_A, sym_A);
        push_exp(16'd11, sym_C, sym_C);
        push_exp(16'd12, sym_G, sym_G);
        send_read(16'd10, 4'h0, 4'h0, 0);
        send_read(16'd11, 4'h1, 4'h1, 0);
        repeat (3) @(negedge clk);
        check_val("both_full_tready", 64'(axis.tready), 64'd0);
        check_val("both_full_issue", 64'(fsm_state.issue_state), 64'(I_Running));
        send_read(16'd12, 4'h2, 4'h2, 0);
        wait_starts(7, 600);
        check_val("read_cnt_7", 64'(read_cnt), 64'd7);
        repeat (busy_cycles + 8) @(negedge clk);
        busy_cycles = 5;

        // Reset in the middle of a packet, with a header already presented.
        send_read(16'd20, 4'h3, 4'h3, 3);
        axis.tdata  = {48'hA5A5_0F0F_C3C3, 16'd21};
        axis.tlast  = 1'b0;
        axis.tvalid = 1'b1;
        reset_n     = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        prev = start_count;
        push_exp(16'd21, sym_T, sym_C);
        send_read(16'd21, 4'h3, 4'h1, 0);
        wait_starts(prev + 1, 50);
        check_val("post_reset_latency", 64'(start_cyc - last_acc_cyc), 64'd2);
        check_val("post_reset_read_cnt", 64'(read_cnt), 64'd1);
        check_val("post_reset_drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (busy_cycles + 8) @(negedge clk);

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
